// File: rtl/de2_input_ctrl.sv
// DE2 switch/push-button input peripheral: two-flop synchronizers, sampled
// 3-of-3 debounce, sticky press events and a 4-word CPU register file with irq.
module de2_input_ctrl #(
    parameter int SAMPLE_PERIOD = 67500,
    parameter int PRESC_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] sw_in,
    input  logic [3:0]  key_in,
    input  logic [1:0]  addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SAMPLE_PERIOD - 1);

    logic [17:0]        sw_s1, sw_s2, sw_h0, sw_h1, db_sw, sw_stable, db_sw_next;
    logic [3:0]         key_s1, key_s2, key_h0, key_h1, db_key, key_stable, db_key_next;
    logic [3:0]         evt, evt_next, key_fall, evt_clr;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               irq_en;
    logic [31:0]        reg_val;
    logic               unused_wr_bits;

    assign unused_wr_bits = ^wr_data[31:4];
    assign tick = (presc == PRESC_MAX);

    // A bit's debounced value moves only when the new sample agrees with both
    // history samples, i.e. three consecutive equal samples.
    always_comb begin
        sw_stable   = ~(sw_s2 ^ sw_h0) & ~(sw_s2 ^ sw_h1);
        key_stable  = ~(key_s2 ^ key_h0) & ~(key_s2 ^ key_h1);
        db_sw_next  = db_sw;
        db_key_next = db_key;
        if (tick) begin
            db_sw_next  = (db_sw & ~sw_stable) | (sw_s2 & sw_stable);
            db_key_next = (db_key & ~key_stable) | (key_s2 & key_stable);
        end
    end

    // rd_en/wr_en are single-cycle strobes with no ready: each asserted cycle is
    // exactly one access, and a write always completes on the edge it is seen.
    always_comb begin
        key_fall = db_key & ~db_key_next;
        evt_clr  = (wr_en && addr == 2'd2) ? wr_data[3:0] : 4'h0;
        evt_next = (evt & ~evt_clr) | key_fall;
    end

    always_comb begin
        reg_val = 32'h0;
        case (addr)
            2'd0: reg_val = {14'h0, db_sw};
            2'd1: reg_val = {28'h0, ~db_key};
            2'd2: reg_val = {28'h0, evt};
            2'd3: reg_val = {31'h0, irq_en};
            default: reg_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_s1   <= 18'h0;
            sw_s2   <= 18'h0;
            sw_h0   <= 18'h0;
            sw_h1   <= 18'h0;
            db_sw   <= 18'h0;
            key_s1  <= 4'hF;
            key_s2  <= 4'hF;
            key_h0  <= 4'hF;
            key_h1  <= 4'hF;
            db_key  <= 4'hF;
            presc   <= '0;
            evt     <= 4'h0;
            irq_en  <= 1'b0;
            irq     <= 1'b0;
            rd_data <= 32'h0;
        end else begin
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
            key_s1 <= key_in;
            key_s2 <= key_s1;
            presc  <= tick ? '0 : presc + PRESC_W'(1);
            if (tick) begin
                sw_h0  <= sw_s2;
                sw_h1  <= sw_h0;
                key_h0 <= key_s2;
                key_h1 <= key_h0;
            end
            db_sw  <= db_sw_next;
            db_key <= db_key_next;
            evt    <= evt_next;
            irq    <= irq_en & (|evt_next);
            if (wr_en && addr == 2'd3)
                irq_en <= wr_data[0];
            if (rd_en)
                rd_data <= reg_val;
        end
    end

endmodule

// File: tb/tb_de2_input_ctrl.sv
// Randomized and directed bench for de2_input_ctrl against a sample-queue
// reference model, with a read scoreboard.
module tb_de2_input_ctrl;

  localparam int SP = 4;
  localparam int PW = 3;

  logic        clk;
  logic        rst;
  logic [17:0] sw_in;
  logic [3:0]  key_in;
  logic [1:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        irq;

  de2_input_ctrl #(.SAMPLE_PERIOD(SP), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .key_in(key_in), .addr(addr),
    .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data), .rd_data(rd_data), .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [17:0] m_sw_line[$];
  logic [3:0]  m_key_line[$];
  logic [17:0] m_sw_smp[$];
  logic [3:0]  m_key_smp[$];
  logic [17:0] m_db_sw;
  logic [3:0]  m_db_key;
  logic [3:0]  m_evt;
  logic        m_irq_en;
  logic        m_irq;
  logic [31:0] m_rd;
  int          m_edges;
  logic        rd_fired;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0: return {14'h0, m_db_sw};
      2'd1: return {28'h0, ~m_db_key};
      2'd2: return {28'h0, m_evt};
      default: return {31'h0, m_irq_en};
    endcase
  endfunction

  // Model: raw inputs reach the sampler two edges late; every SP-th edge a
  // sample is taken, and three equal most-recent samples set the debounced bit.
  task automatic model_edge();
    logic [17:0] s_sw;
    logic [3:0]  s_key, new_key, clr, evt_new;
    rd_fired = 1'b0;
    if (!rst) begin
      m_sw_line  = '{18'h0, 18'h0};
      m_key_line = '{4'hF, 4'hF};
      m_sw_smp   = '{18'h0, 18'h0};
      m_key_smp  = '{4'hF, 4'hF};
      m_db_sw    = 18'h0;
      m_db_key   = 4'hF;
      m_evt      = 4'h0;
      m_irq_en   = 1'b0;
      m_irq      = 1'b0;
      m_rd       = 32'h0;
      m_edges    = 0;
      exp_q.delete();
      return;
    end
    if (rd_en) begin
      m_rd = model_reg(addr);
      exp_q.push_back(m_rd);
      rd_fired = 1'b1;
    end
    s_sw  = m_sw_line.pop_front();
    s_key = m_key_line.pop_front();
    m_sw_line.push_back(sw_in);
    m_key_line.push_back(key_in);
    new_key = m_db_key;
    if ((m_edges % SP) == SP - 1) begin
      m_sw_smp.push_back(s_sw);
      m_key_smp.push_back(s_key);
      if (m_sw_smp.size() > 3) void'(m_sw_smp.pop_front());
      if (m_key_smp.size() > 3) void'(m_key_smp.pop_front());
      for (int b = 0; b < 18; b++)
        if (m_sw_smp[0][b] == m_sw_smp[1][b] && m_sw_smp[1][b] == m_sw_smp[2][b])
          m_db_sw[b] = s_sw[b];
      for (int b = 0; b < 4; b++)
        if (m_key_smp[0][b] == m_key_smp[1][b] && m_key_smp[1][b] == m_key_smp[2][b])
          new_key[b] = s_key[b];
    end
    m_edges++;
    clr = (wr_en && addr == 2'd2) ? wr_data[3:0] : 4'h0;
    evt_new = (m_evt & ~clr) | (m_db_key & ~new_key);
    m_irq = m_irq_en & (|evt_new);
    if (wr_en && addr == 2'd3) m_irq_en = wr_data[0];
    m_evt = evt_new;
    m_db_key = new_key;
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    if (rd_fired) check_eq("rd_data", rd_data, exp_q.pop_front());
    else          check_eq("rd_hold", rd_data, m_rd);
    check_eq("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_read(input logic [1:0] a);
    addr = a; rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    addr = a; wr_en = 1'b1; wr_data = d;
    cycle();
    wr_en = 1'b0; wr_data = 32'h0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    idle(n);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; sw_in = 18'h0; key_in = 4'hF; addr = 2'd0;
    rd_en = 1'b0; wr_en = 1'b0; wr_data = 32'h0;

    // 1. reset / idle
    do_reset(3);
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a));
      check_eq("reset_reg", rd_data, 32'h0);
    end
    idle(100);
    do_read(2'd2);
    check_eq("idle_evt", rd_data, 32'h0);

    // 2. switch debounce latency
    do_reset(1);
    sw_in = 18'h2A5A5;
    for (int i = 0; i < 16; i++) begin
      do_read(2'd0);
      if (i <= 9) check_eq("sw_early", rd_data, 32'h0);
    end
    check_eq("sw_settled", rd_data, 32'h0002A5A5);
    do_write(2'd0, 32'hFFFFFFFF);
    do_read(2'd0);
    check_eq("sw_ro", rd_data, 32'h0002A5A5);

    // 3. glitch rejection at random phase
    for (int r = 0; r < 8; r++) begin
      int ph;
      ph = $urandom_range(0, 12);
      idle(ph);
      key_in[1] = 1'b0;
      idle(3);
      key_in[1] = 1'b1;
      idle(17 - ph);
    end
    do_read(2'd1);
    check_eq("glitch_state", rd_data, 32'h0);
    do_read(2'd2);
    check_eq("glitch_evt", rd_data, 32'h0);

    // 4. press event and W1C
    do_write(2'd3, 32'h1);
    key_in[2] = 1'b0;
    idle(40);
    do_read(2'd1);
    check_eq("press_state", rd_data, 32'h4);
    do_read(2'd2);
    check_eq("press_evt", rd_data, 32'h4);
    check_eq("press_irq", {31'h0, irq}, 32'h1);
    key_in[2] = 1'b1;
    idle(30);
    do_read(2'd1);
    check_eq("release_state", rd_data, 32'h0);
    do_read(2'd2);
    check_eq("release_evt", rd_data, 32'h4);
    do_write(2'd2, 32'h4);
    check_eq("w1c_irq", {31'h0, irq}, 32'h0);
    do_read(2'd2);
    check_eq("w1c_evt", rd_data, 32'h0);

    // 5. set beats clear: W1C bit 0 every cycle until the model's event sets
    key_in[0] = 1'b0;
    addr = 2'd2; wr_en = 1'b1; wr_data = 32'h1;
    for (int i = 0; i < 40 && m_evt[0] == 1'b0; i++) cycle();
    wr_en = 1'b0; wr_data = 32'h0;
    do_read(2'd2);
    check_eq("set_wins", rd_data, 32'h1);
    addr = 2'd3; rd_en = 1'b1; wr_en = 1'b1; wr_data = 32'h0;
    cycle();
    rd_en = 1'b0; wr_en = 1'b0;
    check_eq("rdwr_old", rd_data, 32'h1);
    do_read(2'd3);
    check_eq("rdwr_new", rd_data, 32'h0);

    // 6. reset mid-operation with keys held
    do_write(2'd3, 32'h1);
    key_in = 4'h0;
    idle(40);
    do_read(2'd2);
    check_eq("all_evt", rd_data, 32'hF);
    check_eq("all_irq", {31'h0, irq}, 32'h1);
    do_reset(1);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_eq("rst_rd", rd_data, 32'h0);
    idle(20);
    do_read(2'd2);
    check_eq("refire_evt", rd_data, 32'hF);
    check_eq("refire_irq", {31'h0, irq}, 32'h0);
    key_in = 4'hF;
    idle(30);

    // randomized traffic
    do_write(2'd2, 32'hF);
    do_write(2'd3, 32'h1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) sw_in = 18'($urandom);
      if ($urandom_range(0, 9) == 0)  key_in[$urandom_range(0, 3)] ^= 1'b1;
      addr    = 2'($urandom_range(0, 3));
      rd_en   = ($urandom_range(0, 2) == 0);
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_data = $urandom;
      if (addr == 2'd3 && $urandom_range(0, 3) != 0) wr_data[0] = 1'b1;
      if (i == 300) rst = 1'b0;
      cycle();
      rst = 1'b1;
    end
    rd_en = 1'b0; wr_en = 1'b0;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
